// File: rtl/apb_timer_master_bridge.sv
// Single-outstanding APB4 master: valid/ready command in, APB transfer with
// per-byte parity out, valid/ready response back; aborts stalled transfers.
module apb_timer_master_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [STRB_WIDTH-1:0]   cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_parerr,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STRB_WIDTH-1:0]   PSTRB,
  output logic [ADDR_WIDTH/8-1:0] PADDRCHK,
  output logic [DATA_WIDTH/8-1:0] PWDATACHK,
  output logic                    PSTRBCHK,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic [DATA_WIDTH/8-1:0] PRDATACHK
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,  paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,  pstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  slverr_q, slverr_d;
  logic                  parerr_q, parerr_d;
  logic                  tmo_q,    tmo_d;
  logic [DATA_WIDTH/8-1:0] prdata_par;

  always_comb begin
    prdata_par = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      prdata_par[i] = ^PRDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    parerr_d = parerr_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY takes priority over the timeout limit on the same cycle.
        if (PREADY) begin
          slverr_d = PSLVERR;
          rdata_d  = pwrite_q ? '0 : PRDATA;
          parerr_d = !pwrite_q && (PRDATACHK != prdata_par);
          tmo_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          slverr_d = 1'b1;
          rdata_d  = '0;
          parerr_d = 1'b0;
          tmo_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      parerr_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      parerr_q <= parerr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Parity is derived from the registered bus, so it is stable with it.
  always_comb begin
    PADDRCHK  = '0;
    PWDATACHK = '0;
    for (int i = 0; i < ADDR_WIDTH / 8; i++) PADDRCHK[i] = ^paddr_q[8*i +: 8];
    for (int i = 0; i < DATA_WIDTH / 8; i++) PWDATACHK[i] = ^pwdata_q[8*i +: 8];
  end

  assign PSTRBCHK    = ^pstrb_q;
  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_parerr  = parerr_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_timer_master_bridge.sv
// Bench for apb_timer_master_bridge: directed commands, behavioural APB slave,
// response consumer that checks against a queue of expected responses.
module tb_apb_timer_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [0:0] cmd_strb;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_slverr, rsp_parerr, rsp_timeout;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [0:0] PSTRB, PADDRCHK, PWDATACHK;
  logic       PSTRBCHK;
  logic       PREADY, PSLVERR;
  logic [7:0] PRDATA;
  logic [0:0] PRDATACHK;

  apb_timer_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_parerr(rsp_parerr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PADDRCHK(PADDRCHK), .PWDATACHK(PWDATACHK),
    .PSTRBCHK(PSTRBCHK), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .PRDATACHK(PRDATACHK)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] rdata;
    logic       slverr;
    logic       parerr;
    logic       timeout;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  // slave / consumer knobs
  int   wait_cfg = 0;
  int   stall_cfg = 0;
  logic slverr_cfg = 1'b0;
  logic late_ready = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       rd_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  // Behavioural APB slave: PREADY after wait_cfg wait states.
  initial begin
    int wcnt;
    wcnt = 0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; PRDATACHK = '0;
    forever begin
      @(negedge PCLK);
      PRDATA    = rd_data;
      PRDATACHK = rd_chk;
      if (late_ready) begin
        PREADY = 1'b1;
      end else if (PSEL && PENABLE) begin
        PREADY = (wcnt >= wait_cfg);
        wcnt++;
      end else begin
        PREADY = 1'b0;
        wcnt = 0;
      end
      PSLVERR = PREADY & slverr_cfg;
    end
  end

  // Response monitor: pops the expected response when the DUT presents one.
  initial begin
    int   vcnt;
    logic unstable;
    exp_t e;
    vcnt = 0; unstable = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      rsp_ready = 1'b0;
      if (PRESET) begin
        vcnt = 0; unstable = 1'b0;
      end else if (rsp_valid) begin
        vcnt++;
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
          rsp_ready = 1'b1;
          vcnt = 0;
        end else if (vcnt <= stall_cfg) begin
          if (rsp_rdata !== q[0].rdata || rsp_slverr !== q[0].slverr ||
              rsp_parerr !== q[0].parerr || rsp_timeout !== q[0].timeout)
            unstable = 1'b1;
        end else begin
          e = q.pop_front();
          chk("rsp_rdata",   32'(rsp_rdata),   32'(e.rdata));
          chk("rsp_slverr",  32'(rsp_slverr),  32'(e.slverr));
          chk("rsp_parerr",  32'(rsp_parerr),  32'(e.parerr));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
          chk("rsp_stable",  32'(unstable),    32'd0);
          chk("rsp_hold_cycles", 32'(vcnt), 32'(stall_cfg + 1));
          rsp_ready = 1'b1;
          hs_cyc = cyc + 1;
          vcnt = 0; unstable = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("cmd_ready_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_cmd(input logic w, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic strb, input logic x_achk, input logic x_dchk,
                        input logic x_schk, input logic x_strb,
                        output int psel_n, output int en_n, output int acc_gap);
    logic ok;
    logic moved;
    psel_n = 0; en_n = 0; acc_gap = -1; moved = 1'b0;
    wait_ready(ok);
    cmd_write = w; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    cmd_valid = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    acc_gap = cyc - hs_cyc;
    chk("setup_psel",     32'(PSEL),      32'd1);
    chk("setup_penable",  32'(PENABLE),   32'd0);
    chk("setup_cmd_ready",32'(cmd_ready), 32'd0);
    chk("setup_pwrite",   32'(PWRITE),    32'(w));
    chk("setup_paddr",    32'(PADDR),     32'(addr));
    chk("setup_pstrb",    32'(PSTRB),     32'(x_strb));
    chk("setup_paddrchk", 32'(PADDRCHK),  32'(x_achk));
    chk("setup_pwdatachk",32'(PWDATACHK), 32'(x_dchk));
    chk("setup_pstrbchk", 32'(PSTRBCHK),  32'(x_schk));
    for (int i = 0; i < 200 && PSEL; i++) begin
      psel_n++;
      if (PENABLE) en_n++;
      if (PADDR !== addr || PWRITE !== w || PSTRB !== x_strb || PWDATA !== wdata ||
          PADDRCHK !== x_achk || PWDATACHK !== x_dchk || PSTRBCHK !== x_schk || cmd_ready)
        moved = 1'b1;
      @(negedge PCLK);
    end
    chk("apb_stable_during_transfer", 32'(moved), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge PCLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int   ps, en, gap;
    logic ok;
    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_rdata, rsp_slverr, rsp_parerr, rsp_timeout}), 32'd0);
    chk("rst_apb_ctl",   32'({PSEL, PENABLE, PWRITE}), 32'd0);
    chk("rst_apb_bus",   32'({PADDR, PWDATA, PSTRB}), 32'd0);
    chk("rst_chk",       32'({PADDRCHK, PWDATACHK, PSTRBCHK}), 32'd0);
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;

    // Write 0x5A @0x02, strb 1, two wait states.
    wait_cfg = 2;
    q.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
    do_cmd(1'b1, 8'h02, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ps, en, gap);
    chk("wr_psel_cycles", 32'(ps), 32'd4);
    chk("wr_access_cycles", 32'(en), 32'd3);
    drain();

    // Read 0x03, PRDATA 0x81 with good parity, consumer stalls 3 cycles.
    wait_cfg = 0; stall_cfg = 3; rd_data = 8'h81; rd_chk = 1'b0;
    q.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    do_cmd(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ps, en, gap);
    chk("rd_psel_cycles", 32'(ps), 32'd2);
    drain();
    stall_cfg = 0;

    // Read with bad PRDATACHK.
    rd_chk = 1'b1;
    q.push_back('{8'h81, 1'b0, 1'b1, 1'b0});
    do_cmd(1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps, en, gap);
    drain();
    rd_chk = 1'b0;

    // Write 0x3F with PSLVERR, then a read accepted the cycle after rsp_ready.
    slverr_cfg = 1'b1;
    q.push_back('{8'h00, 1'b1, 1'b0, 1'b0});
    do_cmd(1'b1, 8'h3F, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ps, en, gap);
    slverr_cfg = 1'b0;
    q.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    do_cmd(1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ps, en, gap);
    chk("accept_after_rsp_ready_gap", 32'(gap), 32'd1);
    drain();

    // PREADY never arrives: abort after 16 ACCESS cycles.
    wait_cfg = 1000;
    q.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
    do_cmd(1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ps, en, gap);
    chk("tmo_access_cycles", 32'(en), 32'd16);
    chk("tmo_psel_cycles", 32'(ps), 32'd17);
    drain();
    wait_ready(ok);
    late_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("late_pready_ignored", 32'({cmd_ready, PSEL, rsp_valid}), 32'b100);
    end
    late_ready = 1'b0;

    // Reset during ACCESS, then a fresh read.
    wait_ready(ok);
    cmd_write = 1'b0; cmd_addr = 8'h10; cmd_strb = 1'b0; cmd_valid = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("pre_reset_in_access", 32'({PSEL, PENABLE}), 32'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("midrst_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_paddr", 32'(PADDR), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_cfg = 0;
    q.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    do_cmd(1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps, en, gap);
    chk("post_rst_psel_cycles", 32'(ps), 32'd2);
    drain();
    repeat (3) @(negedge PCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
